// File: rtl/residual_adder_rd_ctrl.sv
// residual_adder_rd_ctrl: streams len words from residual+global SRAMs in lockstep, emits int8 lane sums with dst addresses.
// Latency: sum valid RD_LAT+1 cycles after the matching ren; done one cycle after the last valid (len+RD_LAT+2 from start).
// Backpressure: none, one read per cycle and every valid must be taken; RS_ADDER_SAT_EN selects saturating lanes (wrap otherwise).
module residual_adder_rd_ctrl #(
  parameter int ADDR_W = 9,
  parameter int LANE_W = 8,
  parameter int LANES  = 16,
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W:0]         cfg_len,
  input  logic [ADDR_W-1:0]       cfg_src_base,
  input  logic [ADDR_W-1:0]       cfg_dst_base,
  output logic                    residual_sram_ren,
  output logic [ADDR_W-1:0]       residual_sram_raddr,
  input  logic [LANES*LANE_W-1:0] residual_sram_rdata,
  output logic                    global_sram_ren,
  output logic [ADDR_W-1:0]       global_sram_raddr,
  input  logic [LANES*LANE_W-1:0] global_sram_rdata,
  output logic [LANES*LANE_W-1:0] rs_adder_out_data,
  output logic                    rs_adder_out_data_vld,
  output logic [ADDR_W-1:0]       rs_adder_out_addr,
  output logic                    busy,
  output logic                    done
);

  localparam int DATA_W = LANES * LANE_W;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     issue_cnt_q, issue_cnt_d;
  logic [ADDR_W:0]     out_cnt_q, out_cnt_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic                ren_q, ren_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic [RD_LAT-1:0]   vld_pipe_q, vld_pipe_d;
  logic                rd_emerge;
  logic                out_vld_q, out_vld_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [DATA_W-1:0]   sum;

  // Read data for an issued word is on the SRAM ports while its tracking bit sits at the pipe tail
  assign rd_emerge = vld_pipe_q[RD_LAT-1];

  // Job FSM: config latch, read issue sequencing, drain wait and done pulse
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    src_d       = src_q;
    dst_d       = dst_q;
    issue_cnt_d = issue_cnt_q;
    ren_d       = 1'b0;
    raddr_d     = raddr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_len != '0) begin
            len_d       = cfg_len;
            src_d       = cfg_src_base;
            dst_d       = cfg_dst_base;
            ren_d       = 1'b1;
            raddr_d     = cfg_src_base;
            issue_cnt_d = (ADDR_W+1)'(1);
            state_d     = ISSUE;
          end else begin
            state_d = FIN;
          end
        end
      end
      ISSUE: begin
        // issue_cnt counts reads already on the ren/raddr registers
        if (issue_cnt_q == len_q) begin
          state_d = DRAIN;
        end else begin
          ren_d       = 1'b1;
          raddr_d     = src_q + issue_cnt_q[ADDR_W-1:0];
          issue_cnt_d = issue_cnt_q + (ADDR_W+1)'(1);
        end
      end
      DRAIN: begin
        if (out_cnt_q == len_q) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift register tracking each issued read until its data is valid
  always_comb begin
    vld_pipe_d    = '0;
    vld_pipe_d[0] = ren_q;
    for (int i = 1; i < RD_LAT; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
  end

  // Lane-wise signed add of the residual and global words
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
`ifdef RS_ADDER_SAT_EN
      logic [LANE_W-1:0] a;
      logic [LANE_W-1:0] b;
      logic [LANE_W:0]   ext;
      a   = residual_sram_rdata[i*LANE_W +: LANE_W];
      b   = global_sram_rdata[i*LANE_W +: LANE_W];
      ext = {a[LANE_W-1], a} + {b[LANE_W-1], b};
      // Sign bits disagree only when the true sum leaves the int8 range
      if (ext[LANE_W] != ext[LANE_W-1]) begin
        sum[i*LANE_W +: LANE_W] = ext[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}}
                                              : {1'b0, {(LANE_W-1){1'b1}}};
      end else begin
        sum[i*LANE_W +: LANE_W] = ext[LANE_W-1:0];
      end
`else
      sum[i*LANE_W +: LANE_W] = residual_sram_rdata[i*LANE_W +: LANE_W]
                              + global_sram_rdata[i*LANE_W +: LANE_W];
`endif
    end
  end

  // Output registers load as tracked reads emerge; data and address hold otherwise
  always_comb begin
    out_vld_d  = 1'b0;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    out_cnt_d  = out_cnt_q;
    if (state_q == FIN) out_cnt_d = '0;
    if (rd_emerge) begin
      out_vld_d  = 1'b1;
      out_data_d = sum;
      out_addr_d = dst_q + out_cnt_q[ADDR_W-1:0];
      out_cnt_d  = out_cnt_q + (ADDR_W+1)'(1);
    end
  end

  // State register with synchronous active-low reset; reset aborts any job in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      ren_q       <= 1'b0;
      raddr_q     <= '0;
      vld_pipe_q  <= '0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      ren_q       <= ren_d;
      raddr_q     <= raddr_d;
      vld_pipe_q  <= vld_pipe_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
    end
  end

  assign residual_sram_ren     = ren_q;
  assign residual_sram_raddr   = raddr_q;
  assign global_sram_ren       = ren_q;
  assign global_sram_raddr     = raddr_q;
  assign rs_adder_out_data     = out_data_q;
  assign rs_adder_out_data_vld = out_vld_q;
  assign rs_adder_out_addr     = out_addr_q;
  assign busy                  = (state_q == ISSUE) || (state_q == DRAIN);
  assign done                  = (state_q == FIN);

endmodule

// File: tb/tb_residual_adder_rd_ctrl.sv
module tb_residual_adder_rd_ctrl;

  logic         clk, rst_n;
  logic         start1, start3, sel;
  logic [9:0]   cfg_len;
  logic [8:0]   cfg_src, cfg_dst;

  logic         r1_ren, g1_ren, o1_vld, o1_busy, o1_done;
  logic [8:0]   r1_raddr, g1_raddr, o1_addr;
  logic [127:0] r1_rdata, g1_rdata, o1_data;
  logic         r3_ren, g3_ren, o3_vld, o3_busy, o3_done;
  logic [8:0]   r3_raddr, g3_raddr, o3_addr;
  logic [127:0] r3_rdata, g3_rdata, o3_data, r3_a, r3_b, g3_a, g3_b;

  logic         m_ren, m_gren, m_vld, m_busy, m_done;
  logic [8:0]   m_raddr, m_graddr, m_addr;
  logic [127:0] m_data;

  logic [127:0] res_mem [512];
  logic [127:0] glb_mem [512];

  int n_chk, n_err;
  int ren_c[$], raddr_v[$], vld_c[$], vadr[$], done_c[$], busy_c[$];
  logic [127:0] vdat[$];
  int split, post_rst_nz;

  residual_adder_rd_ctrl #(.RD_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cfg_len(cfg_len),
    .cfg_src_base(cfg_src), .cfg_dst_base(cfg_dst),
    .residual_sram_ren(r1_ren), .residual_sram_raddr(r1_raddr), .residual_sram_rdata(r1_rdata),
    .global_sram_ren(g1_ren), .global_sram_raddr(g1_raddr), .global_sram_rdata(g1_rdata),
    .rs_adder_out_data(o1_data), .rs_adder_out_data_vld(o1_vld), .rs_adder_out_addr(o1_addr),
    .busy(o1_busy), .done(o1_done));

  residual_adder_rd_ctrl #(.RD_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .cfg_len(cfg_len),
    .cfg_src_base(cfg_src), .cfg_dst_base(cfg_dst),
    .residual_sram_ren(r3_ren), .residual_sram_raddr(r3_raddr), .residual_sram_rdata(r3_rdata),
    .global_sram_ren(g3_ren), .global_sram_raddr(g3_raddr), .global_sram_rdata(g3_rdata),
    .rs_adder_out_data(o3_data), .rs_adder_out_data_vld(o3_vld), .rs_adder_out_addr(o3_addr),
    .busy(o3_busy), .done(o3_done));

  always #5 clk = ~clk;

  // SRAM models: data appears RD_LAT cycles after ren; junk when no read was issued
  always @(posedge clk) begin
    r1_rdata <= r1_ren ? res_mem[r1_raddr] : {$urandom, $urandom, $urandom, $urandom};
    g1_rdata <= g1_ren ? glb_mem[g1_raddr] : {$urandom, $urandom, $urandom, $urandom};
    r3_a     <= r3_ren ? res_mem[r3_raddr] : {$urandom, $urandom, $urandom, $urandom};
    g3_a     <= g3_ren ? glb_mem[g3_raddr] : {$urandom, $urandom, $urandom, $urandom};
    r3_b     <= r3_a;
    g3_b     <= g3_a;
    r3_rdata <= r3_b;
    g3_rdata <= g3_b;
  end

  assign m_ren    = sel ? r3_ren   : r1_ren;
  assign m_gren   = sel ? g3_ren   : g1_ren;
  assign m_raddr  = sel ? r3_raddr : r1_raddr;
  assign m_graddr = sel ? g3_raddr : g1_raddr;
  assign m_vld    = sel ? o3_vld   : o1_vld;
  assign m_data   = sel ? o3_data  : o1_data;
  assign m_addr   = sel ? o3_addr  : o1_addr;
  assign m_busy   = sel ? o3_busy  : o1_busy;
  assign m_done   = sel ? o3_done  : o1_done;

  // Reference: int8 lane add, clamped or wrapped according to the build
  function automatic logic [127:0] lane_sum(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] r;
    logic [7:0]   la, lb;
    int s;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      la = a[i*8 +: 8];
      lb = b[i*8 +: 8];
      s  = int'($signed(la)) + int'($signed(lb));
`ifdef RS_ADDER_SAT_EN
      if (s > 127)  s = 127;
      if (s < -128) s = -128;
`endif
      r[i*8 +: 8] = 8'(s);
    end
    return r;
  endfunction

  function automatic logic [127:0] exp_word(input int src, input int k);
    return lane_sum(res_mem[(src + k) % 512], glb_mem[(src + k) % 512]);
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 512; i++) begin
      res_mem[i] = {$urandom, $urandom, $urandom, $urandom};
      glb_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  // Launch one job and record every observed event, cycle 1 being the cycle after start
  task automatic run_job(input int lat, input int len, input int src, input int dst,
                         input int mid_at, input int rst_after, input int ncyc);
    int rst_edge;
    rst_edge = -1;
    ren_c.delete(); raddr_v.delete(); vld_c.delete(); vdat.delete(); vadr.delete();
    done_c.delete(); busy_c.delete();
    split = 0;
    post_rst_nz = -1;
    sel = (lat == 3);
    cfg_len = 10'(len);
    cfg_src = 9'(src);
    cfg_dst = 9'(dst);
    if (lat == 3) start3 = 1'b1; else start1 = 1'b1;
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk); #1;
      start1 = 1'b0;
      start3 = 1'b0;
      if (n == rst_edge) begin
        post_rst_nz = int'(m_ren | m_gren | m_vld | m_busy | m_done | (|m_data) | (|m_addr)
                           | (|m_raddr) | (|m_graddr));
        rst_n = 1'b1;
      end
      if (m_ren) begin ren_c.push_back(n); raddr_v.push_back(int'(m_raddr)); end
      if ((m_ren !== m_gren) || (m_raddr !== m_graddr)) split++;
      if (m_vld) begin vld_c.push_back(n); vdat.push_back(m_data); vadr.push_back(int'(m_addr)); end
      if (m_done) done_c.push_back(n);
      if (m_busy) busy_c.push_back(n);
      if (n == mid_at) begin
        cfg_len = 10'd2; cfg_src = 9'd100; cfg_dst = 9'd200;
        if (lat == 3) start3 = 1'b1; else start1 = 1'b1;
      end
      if (rst_after > 0 && rst_edge < 0 && vld_c.size() == rst_after) begin
        rst_n = 1'b0;
        rst_edge = n + 1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (o1_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b want 0", o1_vld); end
    n_chk++; if (r1_ren !== 1'b0 || g1_ren !== 1'b0) begin n_err++; $display("FAIL reset_ren: got %b/%b want 0", r1_ren, g1_ren); end
    n_chk++; if (o1_busy !== 1'b0 || o1_done !== 1'b0) begin n_err++; $display("FAIL reset_busy_done: got %b/%b want 0", o1_busy, o1_done); end
    n_chk++; if (o1_data !== 128'd0 || o1_addr !== 9'd0 || r1_raddr !== 9'd0) begin
      n_err++; $display("FAIL reset_data_addr: got %h/%h/%h want 0", o1_data, o1_addr, r1_raddr); end
    n_chk++; if (o3_vld !== 1'b0 || o3_busy !== 1'b0 || r3_ren !== 1'b0) begin
      n_err++; $display("FAIL reset_lat3: got %b%b%b want 000", o3_vld, o3_busy, r3_ren); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin res_mem[i] = {16{8'h01}}; glb_mem[i] = {16{8'h02}}; end
    run_job(1, 4, 0, 16, -1, -1, 10);
    n_chk++; if (ren_c.size() != 4) begin n_err++; $display("FAIL basic_ren_count: got %0d want 4", ren_c.size()); end
    n_chk++; if (vld_c.size() != 4) begin n_err++; $display("FAIL basic_vld_count: got %0d want 4", vld_c.size()); end
    for (int k = 0; k < ren_c.size() && k < 4; k++) begin
      n_chk++; if (ren_c[k] != k + 1 || raddr_v[k] != k) begin
        n_err++; $display("FAIL basic_ren[%0d]: got cyc %0d addr %0d want cyc %0d addr %0d", k, ren_c[k], raddr_v[k], k + 1, k); end
    end
    for (int k = 0; k < vld_c.size() && k < 4; k++) begin
      n_chk++; if (vld_c[k] != k + 3) begin n_err++; $display("FAIL basic_vld_cyc[%0d]: got %0d want %0d", k, vld_c[k], k + 3); end
      n_chk++; if (vdat[k] !== {16{8'h03}} || vadr[k] != 16 + k) begin
        n_err++; $display("FAIL basic_out[%0d]: got %h @%0d want %h @%0d", k, vdat[k], vadr[k], {16{8'h03}}, 16 + k); end
    end
    n_chk++; if (done_c.size() != 1 || (done_c.size() == 1 && done_c[0] != 7)) begin
      n_err++; $display("FAIL basic_done: got %0d pulses first %0d want 1 pulse at 7", done_c.size(), done_c.size() > 0 ? done_c[0] : -1); end
    n_chk++; if (busy_c.size() != 6 || (busy_c.size() > 0 && busy_c[0] != 1)) begin
      n_err++; $display("FAIL basic_busy: got %0d cycles want 6", busy_c.size()); end
    n_chk++; if (split != 0) begin n_err++; $display("FAIL basic_lockstep: got %0d splits want 0", split); end
  endtask

  task automatic test_overflow();
    logic [127:0] e0, e1;
`ifdef RS_ADDER_SAT_EN
    e0 = {16{8'h7F}}; e1 = {16{8'h80}};
`else
    e0 = {16{8'h90}}; e1 = {16{8'h7F}};
`endif
    res_mem[40] = {16{8'h70}}; glb_mem[40] = {16{8'h20}};
    res_mem[41] = {16{8'h80}}; glb_mem[41] = {16{8'hFF}};
    run_job(1, 2, 40, 0, -1, -1, 8);
    n_chk++; if (vld_c.size() != 2) begin n_err++; $display("FAIL ovf_count: got %0d want 2", vld_c.size()); end
    if (vld_c.size() >= 2) begin
      n_chk++; if (vdat[0] !== e0) begin n_err++; $display("FAIL ovf_pos: got %h want %h", vdat[0], e0); end
      n_chk++; if (vdat[1] !== e1) begin n_err++; $display("FAIL ovf_neg: got %h want %h", vdat[1], e1); end
    end
  endtask

  task automatic test_wrap();
    int exp_ra[3], exp_oa[3];
    exp_ra = '{510, 511, 0};
    exp_oa = '{511, 0, 1};
    fill_random();
    run_job(1, 3, 510, 511, -1, -1, 9);
    n_chk++; if (ren_c.size() != 3 || vld_c.size() != 3) begin
      n_err++; $display("FAIL wrap_count: got ren %0d vld %0d want 3/3", ren_c.size(), vld_c.size()); end
    for (int k = 0; k < 3; k++) begin
      if (k < raddr_v.size()) begin
        n_chk++; if (raddr_v[k] != exp_ra[k]) begin n_err++; $display("FAIL wrap_raddr[%0d]: got %0d want %0d", k, raddr_v[k], exp_ra[k]); end
      end
      if (k < vadr.size()) begin
        n_chk++; if (vadr[k] != exp_oa[k]) begin n_err++; $display("FAIL wrap_oaddr[%0d]: got %0d want %0d", k, vadr[k], exp_oa[k]); end
        n_chk++; if (vdat[k] !== exp_word(510, k)) begin n_err++; $display("FAIL wrap_data[%0d]: got %h want %h", k, vdat[k], exp_word(510, k)); end
      end
    end
  endtask

  task automatic test_zero_len();
    run_job(1, 0, 5, 5, -1, -1, 6);
    n_chk++; if (ren_c.size() != 0 || vld_c.size() != 0) begin
      n_err++; $display("FAIL zero_activity: got ren %0d vld %0d want 0/0", ren_c.size(), vld_c.size()); end
    n_chk++; if (done_c.size() != 1 || (done_c.size() == 1 && done_c[0] != 1)) begin
      n_err++; $display("FAIL zero_done: got %0d pulses first %0d want 1 at 1", done_c.size(), done_c.size() > 0 ? done_c[0] : -1); end
    n_chk++; if (busy_c.size() != 0) begin n_err++; $display("FAIL zero_busy: got %0d cycles want 0", busy_c.size()); end
  endtask

  task automatic test_busy_start();
    fill_random();
    run_job(1, 8, 20, 40, 3, -1, 16);
    n_chk++; if (vld_c.size() != 8 || ren_c.size() != 8) begin
      n_err++; $display("FAIL busystart_count: got vld %0d ren %0d want 8/8", vld_c.size(), ren_c.size()); end
    n_chk++; if (done_c.size() != 1 || (done_c.size() == 1 && done_c[0] != 11)) begin
      n_err++; $display("FAIL busystart_done: got %0d pulses first %0d want 1 at 11", done_c.size(), done_c.size() > 0 ? done_c[0] : -1); end
    for (int k = 0; k < vadr.size(); k++) begin
      n_chk++; if (vadr[k] != 40 + k || vdat[k] !== exp_word(20, k)) begin
        n_err++; $display("FAIL busystart_out[%0d]: got %h @%0d want %h @%0d", k, vdat[k], vadr[k], exp_word(20, k), 40 + k); end
    end
  endtask

  task automatic test_reset_mid();
    fill_random();
    run_job(1, 16, 0, 0, -1, 5, 30);
    n_chk++; if (post_rst_nz != 0) begin n_err++; $display("FAIL rstmid_outputs: got %0d want 0", post_rst_nz); end
    n_chk++; if (vld_c.size() != 5) begin n_err++; $display("FAIL rstmid_vld: got %0d want 5", vld_c.size()); end
    n_chk++; if (ren_c.size() != 7) begin n_err++; $display("FAIL rstmid_ren: got %0d want 7", ren_c.size()); end
    n_chk++; if (done_c.size() != 0) begin n_err++; $display("FAIL rstmid_done: got %0d want 0", done_c.size()); end
    run_job(1, 3, 7, 9, -1, -1, 8);
    n_chk++; if (vld_c.size() != 3 || done_c.size() != 1 || (done_c.size() == 1 && done_c[0] != 6)) begin
      n_err++; $display("FAIL rstmid_restart: got vld %0d done %0d want 3 vld done at 6", vld_c.size(), done_c.size()); end
    if (vld_c.size() > 0) begin
      n_chk++; if (vdat[0] !== exp_word(7, 0) || vadr[0] != 9) begin
        n_err++; $display("FAIL rstmid_first: got %h @%0d want %h @9", vdat[0], vadr[0], exp_word(7, 0)); end
    end
  endtask

  task automatic test_back_to_back();
    fill_random();
    run_job(3, 2, 30, 60, -1, -1, 8);
    n_chk++; if (ren_c.size() != 2 || vld_c.size() != 2) begin
      n_err++; $display("FAIL lat3_count: got ren %0d vld %0d want 2/2", ren_c.size(), vld_c.size()); end
    for (int k = 0; k < vld_c.size() && k < ren_c.size(); k++) begin
      n_chk++; if (vld_c[k] != ren_c[k] + 4) begin n_err++; $display("FAIL lat3_delay[%0d]: got %0d want %0d", k, vld_c[k] - ren_c[k], 4); end
      n_chk++; if (vdat[k] !== exp_word(30, k)) begin n_err++; $display("FAIL lat3_data[%0d]: got %h want %h", k, vdat[k], exp_word(30, k)); end
    end
    n_chk++; if (done_c.size() != 1 || (done_c.size() == 1 && done_c[0] != 7)) begin
      n_err++; $display("FAIL lat3_done: got %0d pulses want 1 at 7", done_c.size()); end
    run_job(3, 2, 40, 70, -1, -1, 10);
    n_chk++; if (ren_c.size() != 2 || (ren_c.size() > 0 && ren_c[0] != 1)) begin
      n_err++; $display("FAIL b2b_accept: got ren %0d first %0d want 2 first 1", ren_c.size(), ren_c.size() > 0 ? ren_c[0] : -1); end
    n_chk++; if (vld_c.size() != 2 || (vadr.size() > 0 && vadr[0] != 70)) begin
      n_err++; $display("FAIL b2b_out: got %0d vld want 2 starting @70", vld_c.size()); end
    n_chk++; if (done_c.size() != 1 || (done_c.size() == 1 && done_c[0] != 7)) begin
      n_err++; $display("FAIL b2b_done: got %0d pulses want 1 at 7", done_c.size()); end
  endtask

  task automatic test_random();
    int lat, len, src, dst;
    for (int it = 0; it < 8; it++) begin
      fill_random();
      lat = ($urandom_range(0, 1) == 1) ? 3 : 1;
      len = $urandom_range(1, 24);
      src = $urandom_range(0, 511);
      dst = $urandom_range(0, 511);
      run_job(lat, len, src, dst, -1, -1, len + lat + 6);
      n_chk++; if (ren_c.size() != len || vld_c.size() != len) begin
        n_err++; $display("FAIL rnd%0d_count: got ren %0d vld %0d want %0d", it, ren_c.size(), vld_c.size(), len); end
      for (int k = 0; k < ren_c.size(); k++) begin
        n_chk++; if (ren_c[k] != k + 1 || raddr_v[k] != (src + k) % 512) begin
          n_err++; $display("FAIL rnd%0d_ren[%0d]: got cyc %0d addr %0d want cyc %0d addr %0d",
                            it, k, ren_c[k], raddr_v[k], k + 1, (src + k) % 512); end
      end
      for (int k = 0; k < vld_c.size(); k++) begin
        n_chk++; if (vld_c[k] != k + lat + 2 || vadr[k] != (dst + k) % 512) begin
          n_err++; $display("FAIL rnd%0d_vld[%0d]: got cyc %0d addr %0d want cyc %0d addr %0d",
                            it, k, vld_c[k], vadr[k], k + lat + 2, (dst + k) % 512); end
        n_chk++; if (vdat[k] !== exp_word(src, k)) begin
          n_err++; $display("FAIL rnd%0d_data[%0d]: got %h want %h", it, k, vdat[k], exp_word(src, k)); end
      end
      n_chk++; if (done_c.size() != 1 || (done_c.size() == 1 && done_c[0] != len + lat + 2)) begin
        n_err++; $display("FAIL rnd%0d_done: got %0d pulses first %0d want 1 at %0d",
                          it, done_c.size(), done_c.size() > 0 ? done_c[0] : -1, len + lat + 2); end
      n_chk++; if (busy_c.size() != len + lat + 1 || split != 0) begin
        n_err++; $display("FAIL rnd%0d_busy: got %0d busy %0d splits want %0d busy 0 splits",
                          it, busy_c.size(), split, len + lat + 1); end
    end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; sel = 1'b0;
    cfg_len = '0; cfg_src = '0; cfg_dst = '0;
    n_chk = 0; n_err = 0;
    fill_random();
    test_reset();
    test_basic();
    test_overflow();
    test_wrap();
    test_zero_len();
    test_busy_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/residual_adder_rd_ctrl.md
Name: residual_adder_rd_ctrl

Overview:
- Upstream producer of the rs_adder_out_* stream consumed by the residual/global SRAM write controller.
- On a start pulse, streams N 128-bit words from the residual SRAM and the global SRAM in lockstep.
- Adds the two words as 16 signed int8 lanes and emits each sum with its destination word address.
- Used in the residual-add control states.

Parameters:
- ADDR_W, 9, SRAM word-address width; rs_adder_out_addr width.
- LANE_W, 8, lane width in bits (signed).
- LANES, 16, lanes per word; data width = LANES*LANE_W = 128.
- RD_LAT, 1, SRAM read latency in cycles from ren to rdata valid; legal values 1..3.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle job launch; ignored unless idle.
- cfg_len  in  ADDR_W+1  words to process, 0..512; sampled on an accepted start.
- cfg_src_base  in  ADDR_W  first read address, used for both SRAMs; sampled on start.
- cfg_dst_base  in  ADDR_W  first output address; sampled on start.
- residual_sram_ren  out  1  residual SRAM read enable.
- residual_sram_raddr  out  ADDR_W  residual SRAM read address.
- residual_sram_rdata  in  128  residual SRAM read data, valid RD_LAT cycles after ren.
- global_sram_ren  out  1  global SRAM read enable.
- global_sram_raddr  out  ADDR_W  global SRAM read address.
- global_sram_rdata  in  128  global SRAM read data, valid RD_LAT cycles after ren.
- rs_adder_out_data  out  128  lane-wise sum.
- rs_adder_out_data_vld  out  1  sum valid, one cycle per word.
- rs_adder_out_addr  out  ADDR_W  destination word address.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last output word.

Behaviour:
- Reset (rst_n low at a clk edge): every output is 0, FSM goes to IDLE, counters clear. Reset mid-job aborts the job; no further vld or done follows.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE: start with cfg_len>0 latches the config, sets busy the next cycle, goes to ISSUE.
  - start with cfg_len=0 goes to FIN: done pulses next cycle, busy stays 0, no reads, no vld.
- ISSUE: one read per cycle, no bubbles.
  - Both ren signals are 1, both raddr = src_base + issue_cnt, modulo 2^ADDR_W (wraps 511 to 0).
  - issue_cnt increments each cycle. After issuing word len-1, go to DRAIN.
- Read pipeline: a valid/address shift register of depth RD_LAT tracks each issued read.
  - Output registers load when the tracked valid emerges.
  - Latency: rs_adder_out_data_vld goes high exactly RD_LAT+1 cycles after the matching ren.
- Output addressing: rs_adder_out_addr = dst_base + out_cnt, modulo 2^ADDR_W. out_cnt increments per vld.
- DRAIN: ren = 0. When out_cnt reaches len (last vld asserted), go to FIN.
- FIN: done = 1 for one cycle, busy drops the same cycle, return to IDLE.
  - done first cycle = cycle after the last vld.
- A start is accepted the cycle after FIN (back-to-back jobs allowed). start while busy is dropped with no side effects.
- Registers:
  - ren and raddr are registered outputs.
  - When vld=0, rs_adder_out_data holds its last value; addr holds too.
- Arithmetic: each lane i = residual[i*8+:8] + global[i*8+:8], both signed two's complement; the result width is LANE_W. See Optional Feature for overflow handling.
- Total job length: len + RD_LAT + 2 cycles from the start cycle to the done cycle.

Optional Feature:
- Macro RS_ADDER_SAT_EN.
- Defined: each lane saturates; sum >127 gives 127 (0x7F), sum < -128 gives -128 (0x80).
- Undefined: each lane wraps modulo 256 (plain 8-bit add).
- Timing and all other behaviour are identical in both builds.

Test Plan:
- Basic stream: RD_LAT=1, len=4, src=0, dst=0x10, residual lanes=0x01, global lanes=0x02. Expect vld on 4 consecutive cycles starting 2 cycles after the first ren; data lanes 0x03; addr 0x10..0x13; done 1 cycle after the last vld.
- Overflow: residual lane=0x70 (112), global lane=0x20 (32). With RS_ADDER_SAT_EN lane=0x7F; without it lane=0x90. Also 0x80+0xFF: 0x80 saturated vs 0x7F wrapped.
- Wrap-around: src=510, dst=511, len=3. Expect raddr 510,511,0 and out_addr 511,0,1.
- Zero length and busy start: start with len=0 gives done next cycle and no ren or vld. A start pulsed mid-job (len=8) is ignored: exactly 8 vld, one done.
- Reset mid-job: len=16, assert rst_n=0 after 5 outputs. All outputs read 0 the cycle after the reset edge; no further vld or done; a new start after release behaves normally.
- Latency sweep: RD_LAT=3, len=2. vld arrives 4 cycles after each ren; back-to-back start in the cycle after done is accepted.
